// File: rtl/axis_pkt_traffic_gen.sv
// axis_pkt_traffic_gen: AXI-Stream packet generator with INCR/LFSR/CONST/HDR payloads
module axis_pkt_traffic_gen #(
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 8,
    parameter int GAP_WIDTH  = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic [GAP_WIDTH-1:0]  gap_len,
    input  logic [CNT_WIDTH-1:0]  num_pkts,
    input  logic [31:0]           seed,
    output logic [DATA_WIDTH-1:0] axis_tdata,
    output logic                  axis_tvalid,
    output logic                  axis_tlast,
    input  logic                  axis_tready,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  pkts_sent
);
    typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;
    localparam int HW_FULL = CNT_WIDTH + LEN_WIDTH;
    localparam int HW = HW_FULL < DATA_WIDTH ? HW_FULL : DATA_WIDTH;
    state_t                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d, beat_q, beat_d;
    logic [GAP_WIDTH-1:0]  gap_q, gap_d, gcnt_q, gcnt_d;
    logic [CNT_WIDTH-1:0]  num_q, num_d, pkts_q, pkts_d;
    logic [31:0]           seed_q, seed_d, cnt_q, cnt_d, lfsr_q, lfsr_d;
    logic                  hs, last;
    logic [HW_FULL-1:0]    hdr;
    logic [DATA_WIDTH-1:0] lfsr_rep;
    assign axis_tvalid = state_q == SEND;
    assign last        = beat_q == len_q - LEN_WIDTH'(1);
    assign axis_tlast  = axis_tvalid && last;
    assign hs          = axis_tvalid && axis_tready;
    assign busy        = state_q == SEND || state_q == GAP;
    assign done        = state_q == FIN;
    assign pkts_sent   = pkts_q;
    assign hdr         = {pkts_q, len_q};
    // State and counter registers; reset overrides start and handshakes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= '0;
            len_q   <= '0;
            gap_q   <= '0;
            num_q   <= '0;
            seed_q  <= '0;
            beat_q  <= '0;
            gcnt_q  <= '0;
            cnt_q   <= '0;
            lfsr_q  <= '0;
            pkts_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            num_q   <= num_d;
            seed_q  <= seed_d;
            beat_q  <= beat_d;
            gcnt_q  <= gcnt_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            pkts_q  <= pkts_d;
        end
    end
    // Next-state logic: config latched in IDLE, pattern state advances only on handshakes
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        len_d   = len_q;
        gap_d   = gap_q;
        num_d   = num_q;
        seed_d  = seed_q;
        beat_d  = beat_q;
        gcnt_d  = gcnt_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        pkts_d  = pkts_q;
        case (state_q)
            IDLE: if (start) begin
                mode_d  = mode;
                len_d   = pkt_len == '0 ? LEN_WIDTH'(1) : pkt_len;
                gap_d   = gap_len;
                num_d   = num_pkts;
                seed_d  = seed;
                beat_d  = '0;
                cnt_d   = '0;
                lfsr_d  = seed;
                pkts_d  = '0;
                state_d = num_pkts != '0 ? SEND : FIN;
            end
            SEND: if (hs) begin
                cnt_d  = cnt_q + 32'd1;
                lfsr_d = {lfsr_q[30:0], ~(lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0])};
                beat_d = last ? '0 : beat_q + LEN_WIDTH'(1);
                if (last) begin
                    pkts_d  = pkts_q + CNT_WIDTH'(1);
                    gcnt_d  = gap_q - GAP_WIDTH'(1);
                    state_d = pkts_d == num_q ? FIN : gap_q == '0 ? SEND : GAP;
                end
            end
            GAP: begin
                gcnt_d  = gcnt_q - GAP_WIDTH'(1);
                state_d = gcnt_q == '0 ? SEND : GAP;
            end
            default: state_d = IDLE;
        endcase
    end
    // Payload selection; zero whenever no beat is being offered
    always_comb begin
        for (int i = 0; i < DATA_WIDTH; i++) lfsr_rep[i] = lfsr_q[i[4:0]];
        axis_tdata = '0;
        if (state_q == SEND) begin
            if (mode_q == 2'd0) axis_tdata[31:0] = cnt_q;
            else if (mode_q == 2'd1) axis_tdata = lfsr_rep;
            else if (mode_q == 2'd2) axis_tdata[31:0] = seed_q;
            else if (beat_q == '0) axis_tdata[HW-1:0] = hdr[HW-1:0];
            else axis_tdata[LEN_WIDTH-1:0] = beat_q;
        end
    end
endmodule

// File: tb/tb_axis_pkt_traffic_gen.sv
// tb_axis_pkt_traffic_gen: scoreboard bench for the AXI-Stream packet generator
module tb_axis_pkt_traffic_gen;
    logic        clk = 1'b0;
    logic        rst, start, axis_tready, axis_tvalid, axis_tlast, busy, done;
    logic [1:0]  mode;
    logic [7:0]  pkt_len, gap_len;
    logic [15:0] num_pkts, pkts_sent;
    logic [31:0] seed;
    logic [63:0] axis_tdata;

    typedef struct packed {logic [63:0] data; logic last;} beat_t;
    beat_t exp_q[$];
    int checks = 0, failures = 0;
    int rdy_mode = 0;
    logic stall_q = 1'b0, hold_last = 1'b0;
    logic [63:0] hold_data = '0;

    axis_pkt_traffic_gen dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .pkt_len(pkt_len),
        .gap_len(gap_len), .num_pkts(num_pkts), .seed(seed), .axis_tdata(axis_tdata),
        .axis_tvalid(axis_tvalid), .axis_tlast(axis_tlast), .axis_tready(axis_tready),
        .busy(busy), .done(done), .pkts_sent(pkts_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic fb;
        fb = ~(s[31] ^ s[21] ^ s[1] ^ s[0]);
        return {s[30:0], fb};
    endfunction

    task automatic push_run(input logic [1:0] m, input int len, input int num, input logic [31:0] s);
        int eff;
        logic [31:0] inc, l;
        beat_t b;
        eff = len == 0 ? 1 : len;
        inc = 0;
        l = s;
        for (int p = 0; p < num; p++)
            for (int k = 0; k < eff; k++) begin
                case (m)
                    2'd0: b.data = {32'd0, inc};
                    2'd1: b.data = {l, l};
                    2'd2: b.data = {32'd0, s};
                    default: b.data = k == 0 ? {40'd0, 16'(p), 8'(eff)} : 64'(k);
                endcase
                b.last = k == eff - 1;
                exp_q.push_back(b);
                inc++;
                l = lfsr_next(l);
            end
    endtask

    // One cycle: scramble idle config, drive tready, check hold/idle rules and scoreboard beats
    task automatic step();
        beat_t b;
        @(negedge clk);
        start = 1'b0;
        mode = 2'($urandom);
        pkt_len = 8'($urandom);
        gap_len = 8'($urandom);
        num_pkts = 16'($urandom);
        seed = $urandom;
        axis_tready = rdy_mode == 0 ? 1'b1 : rdy_mode == 2 ? 1'b0 : 1'($urandom);
        if (stall_q) begin
            check("hold_valid", 64'(axis_tvalid), 64'd1);
            check("hold_data", axis_tdata, hold_data);
            check("hold_last", 64'(axis_tlast), 64'(hold_last));
        end
        if (!axis_tvalid) begin
            check("idle_data", axis_tdata, 64'd0);
            check("idle_last", 64'(axis_tlast), 64'd0);
        end
        if (axis_tvalid && axis_tready) begin
            check("sb_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                b = exp_q.pop_front();
                check("beat_data", axis_tdata, b.data);
                check("beat_last", 64'(axis_tlast), 64'(b.last));
            end
        end
        stall_q = axis_tvalid && !axis_tready;
        hold_data = axis_tdata;
        hold_last = axis_tlast;
    endtask

    task automatic launch(input logic [1:0] m, input int len, input int gap, input int num, input logic [31:0] s);
        push_run(m, len, num, s);
        mode = m;
        pkt_len = 8'(len);
        gap_len = 8'(gap);
        num_pkts = 16'(num);
        seed = s;
        start = 1'b1;
        step();
        check("lat_valid", 64'(axis_tvalid), 64'(num != 0));
        check("lat_busy", 64'(busy), 64'(num != 0));
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            step();
            n++;
        end
        check("done_seen", 64'(done), 64'd1);
    endtask

    initial begin
        logic [7:0] pat;
        rst = 1'b1;
        start = 1'b0;
        axis_tready = 1'b1;
        mode = '0;
        pkt_len = '0;
        gap_len = '0;
        num_pkts = '0;
        seed = '0;
        step();
        step();
        check("rst_valid", 64'(axis_tvalid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pkts", 64'(pkts_sent), 64'd0);
        rst = 1'b0;
        step();

        launch(2'd0, 4, 0, 2, 32'd0);
        for (int i = 1; i < 8; i++) begin
            step();
            check("b2b_valid", 64'(axis_tvalid), 64'd1);
        end
        step();
        check("incr_done", 64'(done), 64'd1);
        check("incr_busy", 64'(busy), 64'd0);
        check("incr_pkts", 64'(pkts_sent), 64'd2);
        check("incr_drained", 64'(exp_q.size()), 64'd0);
        step();
        check("done_pulse", 64'(done), 64'd0);

        pat = 8'b11100111;
        launch(2'd2, 3, 2, 2, 32'hA5A5A5A5);
        check("gap_pat", 64'(axis_tvalid), 64'(pat[7]));
        for (int i = 1; i < 8; i++) begin
            step();
            check("gap_pat", 64'(axis_tvalid), 64'(pat[7-i]));
        end
        step();
        check("const_done", 64'(done), 64'd1);
        check("const_drained", 64'(exp_q.size()), 64'd0);
        step();

        launch(2'd0, 6, 1, 2, 32'd0);
        step();
        start = 1'b1;
        rdy_mode = 2;
        for (int i = 0; i < 5; i++) step();
        rdy_mode = 0;
        wait_done(100);
        check("bp_pkts", 64'(pkts_sent), 64'd2);
        check("bp_drained", 64'(exp_q.size()), 64'd0);
        step();

        launch(2'd3, 0, 0, 3, 32'd0);
        wait_done(50);
        check("hdr_pkts", 64'(pkts_sent), 64'd3);
        check("hdr_drained", 64'(exp_q.size()), 64'd0);
        step();
        launch(2'd0, 4, 0, 0, 32'd0);
        check("zero_done", 64'(done), 64'd1);
        check("zero_pkts", 64'(pkts_sent), 64'd0);
        step();
        check("zero_done_pulse", 64'(done), 64'd0);

        launch(2'd0, 4, 0, 2, 32'd0);
        step();
        step();
        exp_q.delete();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_valid", 64'(axis_tvalid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_data", axis_tdata, 64'd0);
        check("abort_pkts", 64'(pkts_sent), 64'd0);
        step();
        check("abort_no_done", 64'(done), 64'd0);
        launch(2'd0, 4, 0, 1, 32'd0);
        wait_done(20);
        check("restart_drained", 64'(exp_q.size()), 64'd0);
        step();

        rdy_mode = 1;
        launch(2'd1, 5, 3, 4, 32'hDEADBEEF);
        wait_done(500);
        check("lfsr_pkts", 64'(pkts_sent), 64'd4);
        check("lfsr_drained", 64'(exp_q.size()), 64'd0);
        step();
        launch(2'd1, 3, 0, 2, 32'd0);
        wait_done(200);
        check("lfsr0_pkts", 64'(pkts_sent), 64'd2);
        check("lfsr0_drained", 64'(exp_q.size()), 64'd0);
        rdy_mode = 0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/axis_pkt_traffic_gen.md
AXIS_PKT_TRAFFIC_GEN -- requirements
Module: axis_pkt_traffic_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning AXI-Stream tdata width in bits (legal values 32 or more).
REQ-002 SHALL have parameter LEN_WIDTH, default 8, meaning width of the beats-per-packet field.
REQ-003 SHALL have parameter GAP_WIDTH, default 8, meaning width of the inter-packet idle-cycle field.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, meaning width of the packet-count field and counter.
REQ-005 SHALL use one clock; reset is synchronous and active-high: clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-008 mode  in  2  data pattern: 0 INCR, 1 LFSR, 2 CONST, 3 HDR; latched at start.
REQ-009 pkt_len  in  LEN_WIDTH  beats per packet; latched at start.
REQ-010 gap_len  in  GAP_WIDTH  idle cycles between packets; latched at start.
REQ-011 num_pkts  in  CNT_WIDTH  packets per run; latched at start.
REQ-012 seed  in  32  LFSR seed / CONST value; latched at start.
REQ-013 axis_tdata  out  DATA_WIDTH  stream payload.
REQ-014 axis_tvalid  out  1  stream valid.
REQ-015 axis_tlast  out  1  high on the final beat of each packet.
REQ-016 axis_tready  in  1  downstream ready.
REQ-017 busy  out  1  high while a run is in progress.
REQ-018 done  out  1  one-cycle pulse at run completion.
REQ-019 pkts_sent  out  CNT_WIDTH  packets whose tlast beat has completed a handshake in the current or last run.

Function
REQ-020 SHALL implement states IDLE, SEND, GAP, FIN.
REQ-021 IDLE: start=1 latches config; next state SEND if num_pkts != 0, else FIN; pkts_sent cleared to 0.
REQ-022 Latency: start sampled in cycle N, so axis_tvalid=1 with the first beat in cycle N+1, and busy=1 from cycle N+1.
REQ-023 A handshake occurs when axis_tvalid and axis_tready are both 1 on a rising edge. The beat counter, data pattern and packet counter advance only on a handshake.
REQ-024 While axis_tvalid=1 and axis_tready=0, axis_tdata and axis_tlast SHALL hold stable. axis_tvalid SHALL NOT drop until that handshake completes.
REQ-025 A latched pkt_len of 0 is treated as 1. axis_tlast=1 exactly when beat index = effective length − 1.
REQ-026 Handshake on a tlast beat increments pkts_sent.
  - If pkts_sent+1 == num_pkts: next state FIN.
  - Else if gap_len == 0: stay in SEND, with the next packet's first beat valid in the next cycle (back-to-back).
  - Else: next state GAP.
REQ-027 GAP: axis_tvalid=0 for exactly gap_len cycles, then SEND with beat index 0.
REQ-028 FIN: done=1 for one cycle, axis_tvalid=0, busy=0; next state IDLE.
REQ-029 start while not in IDLE SHALL be ignored. Config input changes mid-run SHALL have no effect.
REQ-030 INCR: 32-bit word counter starting at 0 on start, +1 per handshake, continuing across packets and wrapping 0xFFFFFFFF→0. tdata = counter zero-extended.
REQ-031 LFSR: 32-bit Fibonacci LFSR, taps 32,22,2,1 (XNOR feedback so all-zero is legal), loaded with seed at start and stepped once per handshake. tdata = state replicated across DATA_WIDTH and truncated.
REQ-032 CONST: tdata = seed zero-extended on every beat.
REQ-033 HDR: beat 0 tdata = {pkt index (CNT_WIDTH), effective length (LEN_WIDTH)} zero-extended; beat k>0 tdata = k zero-extended.
REQ-034 In IDLE, GAP and FIN, axis_tdata SHALL be 0 and axis_tlast SHALL be 0.

Reset
REQ-035 rst=1 forces, on the next edge: state IDLE; axis_tdata=0; axis_tvalid=0; axis_tlast=0; busy=0; done=0; pkts_sent=0; INCR counter 0; LFSR 0.
REQ-036 rst mid-packet SHALL abort immediately with no done pulse, and SHALL take priority over start and over handshakes in the same cycle.

Verification
REQ-037 INCR, pkt_len=4, gap_len=0, num_pkts=2, tready=1: 8 consecutive beats with data 0..7 and tlast on beats 3 and 7; done one cycle after beat 7; pkts_sent=2.
REQ-038 CONST seed=0xA5A5A5A5, pkt_len=3, gap_len=2: tvalid pattern 1,1,1,0,0,1,1,1; every beat = 0xA5A5A5A5 zero-extended.
REQ-039 Backpressure: tready=0 for 5 cycles mid-packet. tdata, tlast and tvalid stay stable, and no beat is lost or duplicated (scoreboard against ideal sequence).
REQ-040 pkt_len=0, num_pkts=3, HDR: three single-beat packets, all tlast=1, with headers index 0,1,2 and length 1; num_pkts=0 gives done in cycle N+1 with no tvalid.
REQ-041 rst asserted on beat 2 of 4: next cycle all outputs reset with no done pulse; a new start then restarts INCR data at 0.
REQ-042 Random tready with LFSR mode: received beats match a reference LFSR from seed, and pkts_sent equals num_pkts at done.
